// File: rtl/pixel_serializer.sv
// Pixel word to bit-stream serializer feeding the WS2812 bit writer.
// Shifts GRB words MSB-first over a valid/ready bit handshake and enforces the latch period between frames.
module pixel_serializer #(
    parameter int CLK_HZ       = 12_000_000,
    parameter int LATCH_US     = 80,
    parameter int LATCH_CYCLES = CLK_HZ / 1_000_000 * LATCH_US,
    parameter int UNDERRUN_CYC = LATCH_CYCLES / 2,
    parameter int BITS         = 24
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [BITS-1:0] pixel_data,
    input  logic            pixel_last,
    input  logic            pixel_valid,
    output logic            pixel_ready,
    output logic            bit_value,
    output logic            bit_valid,
    input  logic            bit_ready,
    output logic [15:0]     pixel_count,
    output logic            frame_done,
    output logic            underrun
);

    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam int GW = $clog2(UNDERRUN_CYC + 1);
    localparam int CW = $clog2(BITS);

    localparam logic [1:0] ST_LATCH = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam logic [LW-1:0] LATCH_END = LW'(LATCH_CYCLES - 1);
    localparam logic [GW-1:0] GAP_END   = GW'(UNDERRUN_CYC - 1);
    localparam logic [CW-1:0] BIT_END   = CW'(BITS - 1);

    logic [1:0]      state_r;
    logic [LW-1:0]   latch_cnt_r;
    logic [GW-1:0]   gap_cnt_r;
    logic [CW-1:0]   bit_cnt_r;
    logic [BITS-1:0] shreg_r;
    logic            last_r;
    logic            no_done_r;
    logic            ready_r;
    logic            valid_r;
    logic            done_r;
    logic            underrun_r;
    logic [15:0]     count_r;
    logic            word_xfer_s;
    logic            bit_xfer_s;

    assign word_xfer_s = pixel_valid && ready_r;
    assign bit_xfer_s  = valid_r && bit_ready;

    // Control FSM, shift register and frame bookkeeping
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_LATCH;
            latch_cnt_r <= '0;
            gap_cnt_r   <= '0;
            bit_cnt_r   <= '0;
            shreg_r     <= '0;
            last_r      <= 1'b0;
            no_done_r   <= 1'b1;
            ready_r     <= 1'b0;
            valid_r     <= 1'b0;
            done_r      <= 1'b0;
            underrun_r  <= 1'b0;
            count_r     <= 16'd0;
        end else begin
            done_r     <= 1'b0;
            underrun_r <= 1'b0;
            case (state_r)
                ST_LATCH: begin
                    if (latch_cnt_r == LATCH_END) begin
                        state_r     <= ST_IDLE;
                        ready_r     <= 1'b1;
                        latch_cnt_r <= '0;
                        count_r     <= 16'd0;
                        done_r      <= !no_done_r;
                        no_done_r   <= 1'b0;
                    end else begin
                        latch_cnt_r <= latch_cnt_r + LW'(1);
                    end
                end
                ST_IDLE: begin
                    // An arriving word wins over an expiring gap so nothing is dropped while ready is high
                    if (word_xfer_s) begin
                        shreg_r   <= pixel_data;
                        last_r    <= pixel_last;
                        bit_cnt_r <= '0;
                        gap_cnt_r <= '0;
                        ready_r   <= 1'b0;
                        valid_r   <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end else if (count_r != 16'd0) begin
                        if (gap_cnt_r == GAP_END) begin
                            underrun_r  <= 1'b1;
                            no_done_r   <= 1'b1;
                            gap_cnt_r   <= '0;
                            ready_r     <= 1'b0;
                            latch_cnt_r <= '0;
                            state_r     <= ST_LATCH;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + GW'(1);
                        end
                    end else begin
                        gap_cnt_r <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_xfer_s) begin
                        shreg_r   <= {shreg_r[BITS-2:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                        if (bit_cnt_r == BIT_END) begin
                            valid_r <= 1'b0;
                            if (count_r != 16'hFFFF) begin
                                count_r <= count_r + 16'd1;
                            end else begin
                                count_r <= count_r;
                            end
                            if (last_r) begin
                                latch_cnt_r <= '0;
                                state_r     <= ST_LATCH;
                            end else begin
                                ready_r <= 1'b1;
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            valid_r <= 1'b1;
                        end
                    end else begin
                        valid_r <= valid_r;
                    end
                end
                default: begin
                    state_r     <= ST_LATCH;
                    latch_cnt_r <= '0;
                    no_done_r   <= 1'b1;
                    ready_r     <= 1'b0;
                    valid_r     <= 1'b0;
                end
            endcase
        end
    end

    assign pixel_ready = ready_r;
    assign bit_value   = shreg_r[BITS-1];
    assign bit_valid   = valid_r;
    assign pixel_count = count_r;
    assign frame_done  = done_r;
    assign underrun    = underrun_r;

endmodule
